// File: rtl/router_input_buffer.sv
// Per-port input FIFO for the mesh router: first-word-fall-through head flit,
// registered occupancy exported as a 3-bit congestion figure, sticky error flags.
module router_input_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        stress,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int unsigned CNT_W = 3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Pointer increment with wrap at DEPTH-1; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness and validity depend only on registered count, never on pop.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign stress    = count;

    assign do_push = in_valid & in_ready;
    assign do_pop  = pop & out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                err_overflow <= 1'b1;
            end
            if (pop && !out_valid) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Per-port input FIFO for the mesh router. It accepts 32-bit flits from the link (or the local core) and presents the head flit, first-word-fall-through, to the route-compute stage as its `valid`/`data` inputs. It also exports its registered occupancy as a 3-bit congestion figure, which the neighbouring routers consume as `stress_x`/`stress_y`.

## Interface
- `DATA_W`, 32, flit width.
- `DEPTH`, 4, number of flit slots; legal range 2..7 so occupancy fits in 3 bits.
- `PTR_W`, 2, pointer width; must be at least ceil(log2(DEPTH)).
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  upstream offers `in_data` this cycle.
- `in_data`  input  DATA_W  incoming flit; bits [2:0] carry the destination router address.
- `in_ready`  output  1  buffer can accept a flit this cycle.
- `pop`  input  1  downstream consumed the head flit this cycle; driven by the switch stage when the route-compute `en` fires.
- `out_valid`  output  1  head flit present; drives route-compute `valid`.
- `out_data`  output  DATA_W  head flit; drives route-compute `data`.
- `stress`  output  3  current occupancy, 0..DEPTH.
- `err_overflow`  output  1  sticky flag: a flit was offered while full.
- `err_underflow`  output  1  sticky flag: `pop` was asserted while empty.

## Operation
- Storage is a circular array of DEPTH entries with a write pointer `wr_ptr`, a read pointer `rd_ptr` and a counter `count`, all registered.
- **Push.** A push occurs when `in_valid && in_ready`.
  - The flit is written at `wr_ptr`.
  - `wr_ptr` advances, wrapping from DEPTH-1 to 0. DEPTH need not be a power of two.
- **Pop.** A pop occurs when `pop && out_valid`.
  - `rd_ptr` advances with the same wrap rule.
  - The slot is not cleared.
- **Counter update:**
  - push only: `count` +1.
  - pop only: `count` -1.
  - push and pop in the same cycle: `count` unchanged, both pointers advance.
- **Full.** `in_ready = (count != DEPTH)`. It depends only on registered state; there is no combinational path from `pop`. When full, a simultaneous push and pop therefore pops only.
- **Dropped flit.** `in_valid && !in_ready` drops the flit: storage is untouched and `err_overflow` is set.
- **Pop while empty.** `pop && !out_valid` is ignored for pointers and count, and sets `err_underflow`.
- **Empty with push.** A push and a pop in the same cycle while empty: the push is accepted and the pop is ignored (underflow is flagged).
- **Outputs.**
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`, driven combinationally from registered state.
  - `stress = count`, zero-extended to 3 bits.
- **Reset.** Asserting `rst_n` low at any time, including mid-burst, immediately clears:
  - pointers, count and both error flags;
  - all memory entries, to 0.
  
  Any in-flight flit is lost.
- **Error flags.** They clear only on reset.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data` = 32'h0.
  - `stress` = 0.
  - `err_overflow` = 0 and `err_underflow` = 0.
- **Write-to-read latency is 1 cycle.** A flit pushed at edge N is visible on `out_valid`/`out_data` in the cycle after edge N. Route-compute then registers `port` at edge N+1.
- **Pop.** A pop at edge N presents the next entry, or deasserts `out_valid`, in the cycle after N.
- **`stress` and `in_ready`** reflect the post-edge count in the same cycle in which `out_valid` changes.
- **Throughput.** Sustained throughput is one flit per cycle whenever 0 < count < DEPTH with both push and pop active.
- **`err_*` flags** are registered and assert in the cycle after the offending edge.

## Test plan
- **Reset and single flit.** Hold reset, release, push 32'h0000_0005 once.
  - Expected: `out_valid`=1 with `out_data`=32'h5 and `stress`=1 one cycle later.
  - Then `pop` for one cycle → `out_valid`=0, `stress`=0.
- **Fill to full.** With DEPTH=4, push A1..A4 on back-to-back cycles with no pop → `stress`=4 and `in_ready`=0.
  - Offer A5 → `err_overflow`=1 and `stress` stays 4.
  - Pop four times → order A1, A2, A3, A4; A5 never appears.
- **Full with simultaneous push and pop.** With the buffer full, assert `in_valid` and `pop` together.
  - Expected: head is popped, count becomes 3, the offered flit is dropped with `err_overflow`=1.
  - Next cycle push succeeds and `stress` returns to 4.
- **Wrap-around at DEPTH=5.** Stream 12 flits (values 1..12) with continuous push and pop after a 2-flit prefill.
  - Expected: output sequence 1..12 in order and `stress` constant at 2 throughout the stream.
- **Empty with pop and push.** At `count`=0, assert `pop` alone → `err_underflow`=1 and count stays 0.
  - Then assert `pop` and push 32'hABCD together → `count`=1 and `out_data`=32'hABCD.
- **Reset mid-operation.** With 3 flits stored, drive `rst_n` low asynchronously between edges.
  - Expected: `out_valid`, `stress` and the error flags drop to 0 immediately, `in_ready`=1, and no stale flit appears after release.
